demux1to4_reg: RTL and testbench
================================

Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4-to-1 selector used in the ALU datapath.
- Takes one WIDTH-bit word stream with a 2-bit select and steers each word into one of four output channels.
- Each channel holds its word in a one-entry buffer with a valid/ready handshake and keeps a delivered-word counter.
- Sits after the ALU result mux and fans results out to downstream consumers (register write-back, flags, debug, store).

Parameters:
WIDTH, 32, data word width in bits
CNT_W, 8, width of each per-channel accepted-word counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word present
in_ready  output  1  block can accept the word on in_data this cycle
in_data  input  WIDTH  word to route
sel  input  2  destination channel: 00 to ch0, 01 to ch1, 10 to ch2, 11 to ch3
out_valid  output  4  bit k set means channel k holds a word
out_ready  input  4  bit k set means the channel-k consumer takes its word this cycle
out_data0  output  WIDTH  channel 0 buffered word
out_data1  output  WIDTH  channel 1 buffered word
out_data2  output  WIDTH  channel 2 buffered word
out_data3  output  WIDTH  channel 3 buffered word
cnt0..cnt3  output  CNT_W each  words accepted into channel k since reset

Behaviour:
- Reset (asynchronous, rst=1): out_valid=4'b0000, out_data0..3=0, cnt0..3=0. Outputs clear immediately, without waiting for a clock edge.
  - Words held when reset asserts are discarded; nothing is delivered after reset releases.
  - Operation resumes on the first rising edge with rst=0.
- in_ready is combinational: in_ready = !out_valid[sel] || out_ready[sel]. It depends only on the selected channel; other channels being full never stall the input.
- Accept condition: accept = in_valid && in_ready, sampled at the rising edge.
- On accept, for channel k = sel:
  - out_data_k <= in_data
  - out_valid[k] <= 1
  - cnt_k <= cnt_k + 1
- Latency: a word accepted at edge N is visible on out_data_k with out_valid[k]=1 after edge N (one cycle).
- Drain: when out_valid[k] && out_ready[k] at an edge and channel k is not loaded that edge, out_valid[k] <= 0. out_data_k holds its last value.
- Simultaneous drain and load on the same channel: the load wins. out_valid[k] stays 1, out_data_k takes the new word, and no bubble is inserted. This gives full throughput of one word per cycle into a continuously-ready channel.
- Simultaneous drain of one channel and load of another: the two are independent and both take effect.
- out_ready[k] asserted while out_valid[k]=0 has no effect.
- in_valid=0: no state change except drains.
- Full channel with out_ready[sel]=0: in_ready=0. The upstream must hold in_data and sel stable until accept. No data is overwritten or lost.
- No timing relation is required between sel and in_valid; sel is only meaningful while in_valid=1.
- Counters wrap modulo 2^CNT_W (255+1 -> 0). No saturation and no overflow flag. Counters count accepts, not drains.
- Output data is never X after reset; unselected channel registers never change.

Test Plan:
- Reset: assert rst mid-cycle with ch2 holding 32'hDEADBEEF -> out_valid=0000 and out_data2=0 immediately (before the next edge), cnt2=0; after release, no word appears.
- Routing: send 32'h00000011/22/33/44 with sel=00/01/10/11, all out_ready=0 -> out_valid=1111, out_data0..3=11/22/33/44, cnt0..3=1 each.
- Backpressure: ch1 full and out_ready[1]=0, in_valid=1, sel=01, in_data=32'hAAAA5555 -> in_ready=0, out_data1 unchanged; raise out_ready[1] -> accept on that edge, out_data1=32'hAAAA5555, out_valid[1] stays 1.
- Full throughput: out_ready[3]=1, send 4 consecutive words 1,2,3,4 on sel=11 -> in_ready=1 every cycle, out_data3 follows 1,2,3,4 one cycle late, cnt3=4.
- Independence: ch0 full and stalled, send 32'h12345678 on sel=10 -> in_ready=1, accepted into ch2, ch0 unchanged.
- Counter wrap: 256 accepts into ch0 -> cnt0 reads 255 then 0; cnt1..3 remain 0.

Source files
------------

// File: rtl/demux1to4_reg.sv
//==============================================================================
// Module      : demux1to4_reg
// Description : Registered 1-to-4 demultiplexer. One WIDTH-bit word stream
//               with a 2-bit select is steered into one of four channels.
//               Each channel holds its word in a one-entry buffer with a
//               valid/ready handshake and counts the words it has accepted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      upstream word present
//   in_ready   out  1      word on in_data can be accepted this cycle
//   in_data    in   WIDTH  word to route
//   sel        in   2      destination channel (0..3)
//   out_valid  out  4      bit k: channel k holds a word
//   out_ready  in   4      bit k: channel-k consumer takes its word
//   out_data0..3 out WIDTH buffered word of channel k
//   cnt0..3    out  CNT_W  words accepted into channel k since reset
//==============================================================================
`default_nettype none

module demux1to4_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic accept;

  // Only the selected channel can stall the input; a channel that is being
  // drained this cycle can take a new word on the same edge.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  genvar gk;
  generate
    for (gk = 0; gk < 4; gk++) begin : g_ch
      logic             load;
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q,  data_d;
      logic [CNT_W-1:0] cnt_q,   cnt_d;

      assign load = accept && (sel == 2'(gk));

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load) begin
          // Load takes priority over a simultaneous drain: no bubble.
          valid_d = 1'b1;
          data_d  = in_data;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (out_ready[gk]) begin
          // Data is left as-is on drain; only the valid flag drops.
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          cnt_q   <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          cnt_q   <= cnt_d;
        end
      end

      assign out_valid[gk] = valid_q;
    end
  endgenerate

  assign out_data0 = g_ch[0].data_q;
  assign out_data1 = g_ch[1].data_q;
  assign out_data2 = g_ch[2].data_q;
  assign out_data3 = g_ch[3].data_q;

  assign cnt0 = g_ch[0].cnt_q;
  assign cnt1 = g_ch[1].cnt_q;
  assign cnt2 = g_ch[2].cnt_q;
  assign cnt3 = g_ch[3].cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux1to4_reg.sv
//==============================================================================
// Module      : tb_demux1to4_reg
// Description : Self-checking bench for demux1to4_reg. Accepted words are
//               pushed to a per-channel queue and popped/compared when the
//               consumer drains them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_demux1to4_reg;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  q0[$], q1[$], q2[$], q3[$];
  logic [CW-1:0] cnt_m[4];

  always #5 clk = ~clk;

  demux1to4_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] data_of(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [W-1:0] cnt_of(input int k);
    case (k)
      0:       return W'(cnt0);
      1:       return W'(cnt1);
      2:       return W'(cnt2);
      default: return W'(cnt3);
    endcase
  endfunction

  task automatic push_q(input int k, input logic [W-1:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      2:       q2.push_back(d);
      default: q3.push_back(d);
    endcase
    cnt_m[k] = cnt_m[k] + 1'b1;
  endtask

  task automatic pop_q(input int k, output bit ok, output logic [W-1:0] d);
    ok = 1'b0;
    d  = '0;
    case (k)
      0:       if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
      2:       if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin d = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Consumer side: a word held with out_ready high leaves on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          bit           ok;
          logic [W-1:0] exp;
          pop_q(k, ok, exp);
          if (!ok) chk($sformatf("sb_underflow_ch%0d", k), W'(out_valid[k]), '0);
          else     chk($sformatf("drain_ch%0d", k), data_of(k), exp);
        end
      end
    end
  end

  // Drive one word; called at posedge+1, returns at posedge+1 after accept.
  task automatic send(input int k, input logic [W-1:0] d, input string tag);
    int n = 0;
    in_valid = 1'b1;
    sel      = 2'(k);
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(tag, W'(in_ready), 32'd1);
    if (in_ready) push_q(k, d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_cnt%0d", tag, k), cnt_of(k), W'(cnt_m[k]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) cnt_m[k] = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = 2'b00;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data0", out_data0, '0);
    chk("rst_data3", out_data3, '0);
    chk_counts("rst");
    @(posedge clk); #1;

    // Routing to all four channels, consumers stalled
    send(0, 32'h00000011, "route_rdy0");
    send(1, 32'h00000022, "route_rdy1");
    send(2, 32'h00000033, "route_rdy2");
    send(3, 32'h00000044, "route_rdy3");
    @(negedge clk);
    chk("route_valid", W'(out_valid), 32'hF);
    chk("route_d0", out_data0, 32'h11);
    chk("route_d1", out_data1, 32'h22);
    chk("route_d2", out_data2, 32'h33);
    chk("route_d3", out_data3, 32'h44);
    chk_counts("route");
    @(posedge clk); #1;

    // Backpressure on ch1, then release
    in_valid = 1'b1; sel = 2'b01; in_data = 32'hAAAA5555;
    @(negedge clk);
    chk("bp_ready_low", W'(in_ready), '0);
    @(posedge clk); #1;
    chk("bp_hold_d1", out_data1, 32'h22);
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_ready_high", W'(in_ready), 32'd1);
    if (in_ready) push_q(1, 32'hAAAA5555);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready[1] = 1'b0;
    @(negedge clk);
    chk("bp_d1", out_data1, 32'hAAAA5555);
    chk("bp_valid1", W'(out_valid[1]), 32'd1);
    @(posedge clk); #1;

    // Full throughput on ch3 (drains 44 first, then 1..4)
    out_ready[3] = 1'b1;
    for (int i = 1; i <= 4; i++) send(3, W'(i), "tput_rdy");
    @(negedge clk);
    chk_counts("tput");
    @(posedge clk); #1;
    out_ready[3] = 1'b0;
    @(negedge clk);
    chk("tput_valid3", W'(out_valid[3]), '0);
    chk("tput_d3_hold", out_data3, 32'd4);
    @(posedge clk); #1;

    // Independence: ch0 full/stalled, load ch2 while it drains 33
    out_ready[2] = 1'b1;
    send(2, 32'h12345678, "indep_rdy");
    out_ready[2] = 1'b0;
    @(negedge clk);
    chk("indep_d2", out_data2, 32'h12345678);
    chk("indep_d0", out_data0, 32'h11);
    chk("indep_valid", W'(out_valid), 32'b0111);
    @(posedge clk); #1;

    // Counter wrap on ch0 at full rate
    out_ready[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(0, W'(32'h1000 + i), "wrap_rdy");
      chk("wrap_cnt0", W'(cnt0), W'(cnt_m[0]));
      if (cnt_m[0] == 8'd255) chk("wrap_cnt0_255", W'(cnt0), 32'd255);
      if (cnt_m[0] == 8'd0)   chk("wrap_cnt0_0", W'(cnt0), 32'd0);
    end
    chk_counts("wrap");
    @(negedge clk);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Asynchronous reset with ch2 holding a word
    out_ready[2] = 1'b1;
    send(2, 32'hDEADBEEF, "rst_load");
    out_ready[2] = 1'b0;
    @(negedge clk);
    chk("pre_rst_d2", out_data2, 32'hDEADBEEF);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", W'(out_valid), '0);
    chk("arst_d2", out_data2, '0);
    chk("arst_cnt2", W'(cnt2), '0);
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int k = 0; k < 4; k++) cnt_m[k] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", W'(out_valid), '0);
    end
    chk_counts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
